// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit; the default build has no parity logic.
`ifndef CLKS_PER_BIT
`define CLKS_PER_BIT 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module uart_tx #(
    parameter int CLKS_PER_BIT = `CLKS_PER_BIT,
    parameter int DATA_WIDTH   = `DATA_WIDTH
) (
    input  logic                  sysclk,
    input  logic                  i_rst_n,
    input  logic                  i_tx,
    input  logic                  i_tx_dv,
    input  logic [DATA_WIDTH-1:0] i_tx_byte,
    output logic                  o_tx_ready,
    output logic                  o_tx_serial,
    output logic                  o_tx_active,
    output logic                  o_tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_TX,
        S_TX_ON,
`ifdef UART_TX_PARITY_EN
        S_PARITY_TX,
`endif
        S_STOP_TX,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CW-1:0]         r_clks_cnt;
    logic [CW-1:0]         w_clks_next;
    logic [BW-1:0]         r_bit_idx;
    logic [BW-1:0]         w_bit_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  w_bit_end;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity;
`endif

    assign w_bit_end  = (r_clks_cnt == CW'(CLKS_PER_BIT - 1));
    assign o_tx_ready = (r_state == S_IDLE) && i_tx && i_rst_n;

    always_comb begin
        w_state_next = r_state;
        w_clks_next  = r_clks_cnt;
        w_bit_next   = r_bit_idx;
        w_shift_next = r_shift;
        if (!i_tx) begin
            w_state_next = S_IDLE;
            w_clks_next  = '0;
            w_bit_next   = '0;
            w_shift_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_tx_dv) begin
                        w_state_next = S_START_TX;
                        w_shift_next = i_tx_byte;
                        w_clks_next  = '0;
                        w_bit_next   = '0;
                    end
                end
                S_START_TX: begin
                    if (w_bit_end) begin
                        w_clks_next  = '0;
                        w_state_next = S_TX_ON;
                    end else begin
                        w_clks_next = r_clks_cnt + CW'(1);
                    end
                end
                S_TX_ON: begin
                    if (w_bit_end) begin
                        w_clks_next  = '0;
                        w_shift_next = r_shift >> 1;
                        w_bit_next   = r_bit_idx + BW'(1);
                        if (r_bit_idx == BW'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                            w_state_next = S_PARITY_TX;
`else
                            w_state_next = S_STOP_TX;
`endif
                        end
                    end else begin
                        w_clks_next = r_clks_cnt + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY_TX: begin
                    if (w_bit_end) begin
                        w_clks_next  = '0;
                        w_state_next = S_STOP_TX;
                    end else begin
                        w_clks_next = r_clks_cnt + CW'(1);
                    end
                end
`endif
                S_STOP_TX: begin
                    if (w_bit_end) begin
                        w_clks_next  = '0;
                        w_state_next = S_DONE;
                    end else begin
                        w_clks_next = r_clks_cnt + CW'(1);
                    end
                end
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_clks_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_clks_cnt <= w_clks_next;
            r_bit_idx  <= w_bit_next;
            r_shift    <= w_shift_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the byte at acceptance because the shift register is consumed during the frame.
    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_parity <= 1'b0;
        end else if (!i_tx) begin
            r_parity <= 1'b0;
        end else if (r_state == S_IDLE && i_tx_dv) begin
            r_parity <= ^i_tx_byte;
        end
    end
`endif

    // Line outputs follow the state one cycle later, except an abort which idles the line at once.
    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_tx_serial <= 1'b1;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b0;
        end else if (!i_tx) begin
            o_tx_serial <= 1'b1;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b0;
        end else begin
            o_tx_serial <= 1'b1;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b0;
            case (r_state)
                S_START_TX: begin
                    o_tx_serial <= 1'b0;
                    o_tx_active <= 1'b1;
                end
                S_TX_ON: begin
                    o_tx_serial <= r_shift[0];
                    o_tx_active <= 1'b1;
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY_TX: begin
                    o_tx_serial <= r_parity;
                    o_tx_active <= 1'b1;
                end
`endif
                S_STOP_TX: o_tx_active <= 1'b1;
                S_DONE:    o_tx_done   <= 1'b1;
                default:   o_tx_serial <= 1'b1;
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: serialises one `DATA_WIDTH`-bit byte per frame onto a single line, least-significant bit (LSB) first. Frame is start bit, data bits, optional parity bit, stop bit. It is the transmit-side counterpart of `uart_rx` and shares its bit timing (`CLKS_PER_BIT`) and line levels (`START_BIT`=0, `STOP_BIT`=1, idle=1). It sits between the board-level command/data logic and the TX pin. A byte is accepted through a ready/valid handshake while transmit mode is enabled.

## Interface
- `CLKS_PER_BIT`, default `` `CLKS_PER_BIT `` (uart_params.vh): sysclk cycles per serial bit; must be ≥2.
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (8): data bits per frame.
- `sysclk`  in  1  system clock; all logic on rising edge.
- `i_rst_n`  in  1  reset; asynchronous assert, active-low.
- `i_tx`  in  1  transmit mode enable, active high.
- `i_tx_dv`  in  1  byte valid.
- `i_tx_byte`  in  `DATA_WIDTH`  byte to send.
- `o_tx_ready`  out  1  block can accept a byte this cycle.
- `o_tx_serial`  out  1  serial line, registered.
- `o_tx_active`  out  1  frame in progress (START_TX through STOP_TX).
- `o_tx_done`  out  1  one-cycle pulse after stop bit completes.

## Operation
- States:
  - IDLE: line high.
  - START_TX: drive 0.
  - TX_ON: drive data bit `bit_idx`.
  - PARITY_TX: drive parity bit (only when the parity macro is defined).
  - STOP_TX: drive 1.
  - DONE: drive 1, pulse done.
- Acceptance occurs on an edge where `i_tx && i_tx_dv && o_tx_ready`. At that edge the byte is latched into a shift register, the bit counter clears, and the state moves to START_TX. `i_tx_byte` is ignored afterwards.
- `o_tx_ready` = (state==IDLE) && `i_tx`. `i_tx_dv` is ignored when ready is low; no queuing.
- Each bit state lasts exactly `CLKS_PER_BIT` cycles, timed by a `clks_cnt` counter that counts 0..`CLKS_PER_BIT`-1 and then rolls over.
- Bit sequencing in TX_ON: after `DATA_WIDTH` bits the state moves to PARITY_TX or STOP_TX.
- After STOP_TX the state moves to DONE for 1 cycle (`o_tx_done`=1), then to IDLE.
- `o_tx_active` is high from START_TX through STOP_TX. It is low in IDLE and DONE.
- Abort: if `i_tx`=0 in any state, the next edge forces IDLE with `o_tx_serial`=1, `o_tx_active`=0, and no done pulse. Counters and the shift register clear.
- Reset (`i_rst_n`=0, asynchronous):
  - State is IDLE.
  - `o_tx_serial`=1, `o_tx_active`=0, `o_tx_done`=0.
  - Counters are 0 and the shift register is 0.
  - `o_tx_ready`=0 while in reset, then follows `i_tx`.
- Reset mid-frame truncates the frame; the line returns high asynchronously.
- Counter widths: `clks_cnt` uses $clog2(`CLKS_PER_BIT`) bits; `bit_idx` uses $clog2(`DATA_WIDTH`)+1 bits. No wrap within a frame.

## Timing
- Acceptance edge k: `o_tx_serial` is 0 for cycles k+1..k+`CLKS_PER_BIT`.
- Data bit n (0 = LSB) occupies cycles k+1+(n+1)·`CLKS_PER_BIT` through k+(n+2)·`CLKS_PER_BIT`.
- Frame length F = (`DATA_WIDTH`+2[+1 parity])·`CLKS_PER_BIT` cycles. `o_tx_done`=1 in cycle k+F+1 only.
- Back-to-back with `i_tx_dv` held high: the next acceptance happens in the cycle after DONE. The line is high for exactly 2 cycles between frames (DONE cycle plus IDLE/accept cycle).
- `o_tx_ready` is combinational from state and `i_tx`. All other outputs are registered.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY_TX state is inserted after the last data bit, lasting `CLKS_PER_BIT` cycles.
  - It drives even parity = XOR of the latched byte.
  - Frame is `DATA_WIDTH`+3 bits.
- Undefined: no PARITY_TX state or logic; frame is `DATA_WIDTH`+2 bits.
- The matching receiver must use the same setting.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `DATA_WIDTH`=8.
- Reset: hold `i_rst_n`=0 with `i_tx`=1 and `i_tx_dv`=1 → serial=1, ready=0, active=0, done=0. Release reset → ready=1 on the next cycle.
- Single byte: send 0xA5 at edge k → serial is 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles over cycles k+1..k+40. done=1 only at k+41; active=1 for k+1..k+40.
- Back-to-back: send 0x00 then 0xFF with dv held high → second start bit at k+43. Exactly 2 high cycles between the frames. 8 ones then stop.
- Busy ignore: pulse dv with 0x11 at k+10 during a 0x3C frame → only 0x3C is transmitted; ready=0 throughout the frame.
- Abort: drop `i_tx` at k+15 → serial=1 and active=0 from k+16; no done pulse. Re-enable and send 0x3C → correct frame.
- Parity (macro defined): send 0x07 → parity bit 1 at k+37..k+40, stop at k+41..k+44, done at k+45. Send 0x03 → parity bit 0. Macro undefined → 0x07 frame ends at k+40.
